// File: rtl/dmem_bridge.sv
// Pipeline-to-memory data bridge: one-entry posted write buffer, blocking read
// misses, and a per-transaction ack timeout that latches a sticky error.
module dmem_bridge #(
    parameter int TO_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dm_oen,
    input  logic        dm_wen,
    input  logic [10:0] D_ADDR,
    input  logic [31:0] D_OUT,
    output logic [31:0] D_IN,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;

    localparam logic [3:0]  TO_LIM    = 4'(TO_CYCLES);
    localparam logic [31:0] ABORT_VAL = 32'hDEAD_BEEF;

    logic [1:0]  r_state;
    logic        r_wb_valid;
    logic [10:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_served;
    logic [10:0] r_served_addr;
    logic [3:0]  r_cnt;
    logic [31:0] r_d_in;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [10:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_err;

    logic        w_wr;
    logic        w_rd;
    logic        w_hit;
    logic        w_served_hit;
    logic        w_miss;
    logic        w_timeout;
    logic        w_stall;

    // Write wins when both strobes are low, so a read only exists on its own.
    assign w_wr         = ~dm_wen;
    assign w_rd         = ~dm_oen & dm_wen;
    assign w_hit        = r_wb_valid && (r_wb_addr == D_ADDR);
    assign w_served_hit = r_served && (r_served_addr == D_ADDR);
    assign w_miss       = w_rd && !w_hit && !w_served_hit;
    assign w_timeout    = !mem_ack && ((r_cnt + 4'd1) == TO_LIM);

    always_comb begin
        w_stall = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE:  w_stall = (w_wr && r_wb_valid) || w_miss;
                default: w_stall = w_wr || w_rd;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
            r_served      <= 1'b0;
            r_served_addr <= '0;
            r_cnt         <= '0;
            r_d_in        <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_served <= 1'b0;
                    if (w_rd && w_hit)
                        r_d_in <= r_wb_data;
                    if (w_wr && !r_wb_valid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= D_ADDR;
                        r_wb_data  <= D_OUT;
                    end
                    // A pending read miss goes out ahead of the buffered write.
                    if (w_miss) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= D_ADDR;
                        r_cnt      <= '0;
                        r_state    <= S_RD_WAIT;
                    end else if (r_wb_valid) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wb_addr;
                        r_mem_wdata <= r_wb_data;
                        r_cnt       <= '0;
                        r_state     <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_ack) begin
                        r_d_in        <= mem_rdata;
                        r_mem_req     <= 1'b0;
                        r_served      <= 1'b1;
                        r_served_addr <= r_mem_addr;
                        r_state       <= S_IDLE;
                    end else if (w_timeout) begin
                        // The stalled read is released with the poison value
                        // rather than re-issued against a dead memory.
                        r_d_in        <= ABORT_VAL;
                        r_err         <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_served      <= 1'b1;
                        r_served_addr <= r_mem_addr;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_ack) begin
                        r_wb_valid <= 1'b0;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        r_wb_valid <= 1'b0;
                        r_err      <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign stall     = w_stall;
    assign D_IN      = r_d_in;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios plus a random phase checked against
// a flat word-array model of memory as the pipeline should see it.
module tb_dmem_bridge;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dm_oen, dm_wen;
    logic [10:0] D_ADDR;
    logic [31:0] D_OUT;
    logic [31:0] D_IN;
    logic        stall;
    logic        mem_req, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] gold    [0:2047];
    logic [31:0] mem_arr [0:2047];
    int  ack_delay = 2;
    bit  rnd_ack = 1'b0;
    int  req_age, cur_delay;
    logic        snap_we;
    logic [10:0] snap_addr;
    logic [31:0] snap_wdata;

    dmem_bridge #(.TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .dm_oen(dm_oen), .dm_wen(dm_wen),
        .D_ADDR(D_ADDR), .D_OUT(D_OUT), .D_IN(D_IN), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_9E37);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv_idle();
        dm_oen = 1'b1; dm_wen = 1'b1; D_ADDR = '0; D_OUT = '0;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [31:0] d, input bit both);
        int k = 0;
        @(negedge clk);
        dm_wen = 1'b0; dm_oen = both ? 1'b0 : 1'b1; D_ADDR = a; D_OUT = d;
        #1;
        while (stall !== 1'b0 && k < 40) begin @(negedge clk); #1; k++; end
        chk("wr_accept", 32'(stall), 32'd0);
        if (stall === 1'b0) gold[a] = d;
        @(negedge clk);
        drv_idle();
    endtask

    task automatic do_read(input logic [10:0] a, input string tag);
        int k = 0;
        @(negedge clk);
        dm_oen = 1'b0; dm_wen = 1'b1; D_ADDR = a; D_OUT = $urandom;
        #1;
        while (stall !== 1'b0 && k < 40) begin @(negedge clk); #1; k++; end
        chk("rd_accept", 32'(stall), 32'd0);
        @(negedge clk);
        chk(tag, D_IN, gold[a]);
        drv_idle();
    endtask

    task automatic quiesce(input string tag);
        int k = 0;
        drv_idle();
        repeat (3) @(negedge clk);
        while (mem_req !== 1'b0 && k < 40) begin @(negedge clk); k++; end
        chk(tag, 32'(mem_req), 32'd0);
    endtask

    // Memory responder: acks after a programmed number of request cycles
    // (0 = never) and checks the request fields hold steady while pending.
    initial begin
        for (int i = 0; i < 2048; i++) mem_arr[i] = init_val(i);
        mem_ack = 1'b0; mem_rdata = '0; req_age = 0; cur_delay = 0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req !== 1'b1) begin
                req_age = 0;
            end else begin
                req_age++;
                if (req_age == 1) begin
                    cur_delay  = rnd_ack ? int'($urandom_range(1, 4)) : ack_delay;
                    snap_we    = mem_we;
                    snap_addr  = mem_addr;
                    snap_wdata = mem_wdata;
                end else begin
                    chk("req_we_stable", 32'(mem_we), 32'(snap_we));
                    chk("req_addr_stable", 32'(mem_addr), 32'(snap_addr));
                    chk("req_wdata_stable", mem_wdata, snap_wdata);
                end
                if (cur_delay != 0 && req_age == cur_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_arr[mem_addr];
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1, a1, b1, c1, e1;
        int k;
        for (int i = 0; i < 2048; i++) gold[i] = init_val(i);

        // Reset state, with a read request present that must not stall.
        rst_n = 1'b0;
        dm_oen = 1'b0; dm_wen = 1'b1; D_ADDR = 11'd9; D_OUT = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_d_in", D_IN, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv_idle();

        // Posted write then read hit from the buffer.
        d1 = 32'h1234_5678;
        @(negedge clk);
        dm_wen = 1'b0; D_ADDR = 11'd5; D_OUT = d1;
        #1 chk("t1_wr_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("t1_no_mem_req", 32'(mem_req), 32'd0);
        dm_wen = 1'b1; dm_oen = 1'b0; D_ADDR = 11'd5;
        #1 chk("t1_rd_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("t1_rd_data", D_IN, d1);
        gold[5] = d1;
        quiesce("t1_drain_done");
        chk("t1_mem5", mem_arr[5], d1);

        // Read miss with a 3-cycle ack.
        do_write(11'd9, 32'hCAFE_F00D, 1'b0);
        quiesce("t2_pre_drain");
        ack_delay = 3;
        @(negedge clk);
        dm_oen = 1'b0; dm_wen = 1'b1; D_ADDR = 11'd9;
        #1 chk("t2_miss_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("t2_mem_we", 32'(mem_we), 32'd0);
        chk("t2_mem_addr", 32'(mem_addr), 32'd9);
        chk("t2_wait_stall", 32'(stall), 32'd1);
        k = 0;
        while (mem_req === 1'b1 && k < 40) begin k++; @(negedge clk); end
        #1;
        chk("t2_req_cycles", 32'(k), 32'd3);
        chk("t2_rd_data", D_IN, 32'hCAFE_F00D);
        chk("t2_stall_after_ack", 32'(stall), 32'd0);
        quiesce("t2_idle");

        // Back-to-back writes with a 2-cycle ack.
        ack_delay = 2;
        a1 = $urandom; b1 = $urandom;
        @(negedge clk);
        dm_wen = 1'b0; D_ADDR = 11'd1; D_OUT = a1;
        #1 chk("t3_wr1_stall", 32'(stall), 32'd0);
        gold[1] = a1;
        @(negedge clk);
        D_ADDR = 11'd2; D_OUT = b1;
        #1 chk("t3_wr2_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("t3_drain_req", 32'(mem_req), 32'd1);
        chk("t3_drain_we", 32'(mem_we), 32'd1);
        chk("t3_drain_addr", 32'(mem_addr), 32'd1);
        chk("t3_drain_wdata", mem_wdata, a1);
        @(negedge clk);
        #1 chk("t3_stall_ack_cycle", 32'(stall), 32'd1);
        @(negedge clk);
        #1 chk("t3_wr2_accept", 32'(stall), 32'd0);
        gold[2] = b1;
        @(negedge clk);
        drv_idle();
        chk("t3_buffered_no_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("t3_drain2_addr", 32'(mem_addr), 32'd2);
        chk("t3_drain2_wdata", mem_wdata, b1);
        quiesce("t3_idle");
        chk("t3_mem1", mem_arr[1], a1);
        chk("t3_mem2", mem_arr[2], b1);

        // Read miss is issued before the pending drain.
        c1 = $urandom;
        @(negedge clk);
        dm_wen = 1'b0; D_ADDR = 11'd3; D_OUT = c1;
        #1 chk("t4_wr_stall", 32'(stall), 32'd0);
        gold[3] = c1;
        @(negedge clk);
        dm_wen = 1'b1; dm_oen = 1'b0; D_ADDR = 11'd7;
        #1 chk("t4_miss_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("t4_first_we", 32'(mem_we), 32'd0);
        chk("t4_first_addr", 32'(mem_addr), 32'd7);
        #1;
        k = 0;
        while (stall !== 1'b0 && k < 40) begin @(negedge clk); #1; k++; end
        chk("t4_rd_accept", 32'(stall), 32'd0);
        @(negedge clk);
        drv_idle();
        chk("t4_rd_data", D_IN, gold[7]);
        chk("t4_then_drain_we", 32'(mem_we), 32'd1);
        chk("t4_then_drain_addr", 32'(mem_addr), 32'd3);
        quiesce("t4_idle");

        // Read timeout: no ack ever.
        ack_delay = 0;
        @(negedge clk);
        dm_oen = 1'b0; dm_wen = 1'b1; D_ADDR = 11'd11;
        #1 chk("t5_miss_stall", 32'(stall), 32'd1);
        @(negedge clk);
        k = 0;
        while (mem_req === 1'b1 && k < 40) begin k++; @(negedge clk); end
        drv_idle();
        chk("t5_req_cycles", 32'(k), 32'(TO));
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_d_in", D_IN, 32'hDEAD_BEEF);
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        ack_delay = 2;
        do_write(11'd6, $urandom, 1'b0);
        quiesce("t5_post_idle");
        chk("t5_err_sticky", 32'(err), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("t5_err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a write drain discards the buffered write.
        ack_delay = 0;
        e1 = $urandom;
        @(negedge clk);
        dm_wen = 1'b0; D_ADDR = 11'd4; D_OUT = e1;
        #1 chk("t6_wr_stall", 32'(stall), 32'd0);
        @(negedge clk);
        drv_idle();
        @(negedge clk);
        chk("t6_drain_req", 32'(mem_req), 32'd1);
        chk("t6_drain_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1 chk("t6_async_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_redrain", 32'(mem_req), 32'd0);
        end
        do_read(11'd4, "t6_rd_old");

        // Random traffic on a small address window against the array model.
        rnd_ack = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int op;
            logic [10:0] a;
            op = int'($urandom_range(0, 2));
            a  = 11'($urandom_range(0, 7));
            if (op == 0) begin
                do_write(a, $urandom, 1'($urandom_range(0, 1)));
            end else if (op == 1) begin
                do_read(a, "rnd_rd");
            end else begin
                @(negedge clk);
                drv_idle();
            end
        end
        quiesce("rnd_idle");
        for (int i = 0; i < 8; i++) chk("rnd_mem", mem_arr[i], gold[i]);
        chk("rnd_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
